// File: rtl/uart_pkg.sv
// uart_pkg: shared UART framing types, constants and the even-parity helper
package uart_pkg;
  localparam int WIDTH_DATABITS = 8;
  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;
  localparam logic PARITY_NONE = 1'b0;
  localparam logic PARITY_EVEN = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/uart_tx_baud.sv
// uart_tx_baud: bit-period counter; ports clk, rst_n, en (count), clr (zero), bit_end (last clk of a bit)
module uart_tx_baud #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic bit_end
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  logic [CW-1:0] cnt;
  assign bit_end = en && cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (en) cnt <= bit_end ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter; byte in via valid_in/ready_in, framed serial out on tx, busy/done status
module uart_tx #(
  parameter int WIDTH_DATABITS = uart_pkg::WIDTH_DATABITS,
  parameter int CLKS_PER_BIT = 434,
  parameter int WIDTH_BITCNT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      parity_bit_config,
  input  logic                      stop_bit_config,
  input  logic [WIDTH_DATABITS-1:0] in,
  input  logic                      valid_in,
  output logic                      ready_in,
  output logic                      tx,
  output logic                      busy,
  output logic                      done
);
  import uart_pkg::*;
  state_t state, state_nxt;
  logic [WIDTH_DATABITS-1:0] shift, shift_nxt;
  logic [WIDTH_BITCNT-1:0] idx;
  logic par_q, par_bit, stop_q, stop_idx, tx_nxt, bit_end, xfer, last_data, last_stop;
  assign xfer = valid_in && ready_in;
  assign last_data = idx == WIDTH_BITCNT'(WIDTH_DATABITS - 1);
  assign last_stop = stop_idx || stop_q != STOP_TWO;
  assign busy = state != IDLE;
  uart_tx_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk), .rst_n(rst_n), .en(busy), .clr(!busy), .bit_end(bit_end)
  );
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && last_data) state_nxt = (par_q == PARITY_EVEN) ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end && last_stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // tx is computed from the next state so the line register changes on the same edge as the FSM
  always_comb begin
    shift_nxt = (state == DATA && bit_end) ? shift >> 1 : shift;
    tx_nxt = state_nxt == START ? 1'b0 :
             state_nxt == DATA ? shift_nxt[0] :
             state_nxt == PARITY ? par_bit : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift <= '0;
      idx <= '0;
      par_q <= PARITY_NONE;
      par_bit <= 1'b0;
      stop_q <= STOP_ONE;
      stop_idx <= 1'b0;
      tx <= 1'b1;
      done <= 1'b0;
      ready_in <= 1'b0;
    end else begin
      shift <= xfer ? in : shift_nxt;
      idx <= xfer ? '0 : (state == DATA && bit_end) ? idx + 1'b1 : idx;
      stop_idx <= xfer ? 1'b0 : (state == STOP && bit_end) ? 1'b1 : stop_idx;
      if (xfer) begin
        par_q <= parity_bit_config;
        par_bit <= even_parity(64'(in));
        stop_q <= stop_bit_config;
      end
      tx <= tx_nxt;
      done <= state == STOP && state_nxt == IDLE;
      ready_in <= state_nxt == IDLE;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and random frames checked against a bit-list frame model and a mid-bit receiver
module tb_uart_tx;
  localparam int CPB = 4;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, parity_bit_config = 0, stop_bit_config = 0, valid_in = 0;
  logic [W-1:0] din = '0;
  logic ready_in, tx, busy, done;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  uart_tx #(.WIDTH_DATABITS(W), .CLKS_PER_BIT(CPB), .WIDTH_BITCNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .parity_bit_config(parity_bit_config),
    .stop_bit_config(stop_bit_config), .in(din), .valid_in(valid_in),
    .ready_in(ready_in), .tx(tx), .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic frame(input logic [7:0] b, input bit p, input bit s, input bit hold,
                       input logic [7:0] nb, input bit toggle);
    bit bits[$];
    int len, waited;
    bit flags_ok;
    logic [7:0] dec;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(b[i]);
    if (p) bits.push_back(bit'($countones(b) % 2));
    bits.push_back(1'b1);
    if (s) bits.push_back(1'b1);
    len = bits.size() * CPB;
    din = b; parity_bit_config = p; stop_bit_config = s; valid_in = 1;
    waited = 0;
    while (ready_in !== 1'b1 && waited < 200) begin @(negedge clk); waited++; end
    chk($sformatf("ready_wait %0h", b), ready_in, 1);
    if (ready_in !== 1'b1) begin valid_in = 0; return; end
    @(posedge clk);
    @(negedge clk);
    if (hold) din = nb; else valid_in = 0;
    if (toggle) begin stop_bit_config = ~s; parity_bit_config = ~p; end
    flags_ok = 1; dec = '0;
    for (int j = 0; j < len; j++) begin
      if (j > 0) @(negedge clk);
      chk($sformatf("tx b=%0h j=%0d", b, j), tx, bits[j / CPB]);
      if (ready_in !== 1'b0 || busy !== 1'b1 || done !== 1'b0) flags_ok = 0;
      if (j % CPB == CPB / 2 && j / CPB >= 1 && j / CPB <= W) dec[j / CPB - 1] = tx;
    end
    chk($sformatf("frame_flags %0h", b), flags_ok, 1);
    chk($sformatf("rx_decode %0h", b), dec, b);
    @(negedge clk);
    chk($sformatf("done_cycle %0h", b), {done, ready_in, busy, tx}, 4'b1101);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int waited;
    bit saw_done, saw_busy;
    logic [7:0] rb;
    bit rp, rs;
    repeat (2) @(negedge clk);
    chk("reset_state", {tx, busy, done, ready_in}, 4'b1000);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_reset", {ready_in, tx, busy}, 3'b110);
    frame(8'hA5, 0, 0, 0, 8'h00, 0);
    frame(8'h07, 1, 1, 0, 8'h00, 0);
    frame(8'h03, 1, 1, 0, 8'h00, 0);
    frame(8'h55, 0, 0, 1, 8'hAA, 0);
    frame(8'hAA, 0, 0, 0, 8'h00, 0);
    frame(8'h3A, 0, 0, 0, 8'h00, 1);
    frame(8'hC1, 0, 1, 0, 8'h00, 0);
    din = 8'h96; parity_bit_config = 0; stop_bit_config = 0; valid_in = 1;
    waited = 0;
    while (ready_in !== 1'b1 && waited < 200) begin @(negedge clk); waited++; end
    chk("ready_wait_rst", ready_in, 1);
    @(posedge clk);
    @(negedge clk);
    valid_in = 0;
    repeat (17) @(negedge clk);
    chk("busy_before_abort", busy, 1);
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_abort", {tx, busy, done, ready_in}, 4'b1000);
    rst_n = 1;
    saw_done = 0; saw_busy = 0;
    repeat (50) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1;
      if (busy !== 1'b0 || tx !== 1'b1) saw_busy = 1;
    end
    chk("no_done_after_abort", saw_done, 0);
    chk("idle_after_abort", saw_busy, 0);
    frame(8'h3C, 0, 0, 0, 8'h00, 0);
    frame(8'h11, 1, 0, 1, 8'h22, 0);
    frame(8'h22, 1, 0, 1, 8'h33, 0);
    frame(8'h33, 1, 0, 0, 8'h00, 0);
    saw_busy = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1 || done !== 1'b0) saw_busy = 1;
    end
    chk("sent_once", saw_busy, 0);
    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom);
      rp = 1'($urandom);
      rs = 1'($urandom);
      frame(rb, rp, rs, 0, 8'h00, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
